// File: rtl/bp_cce_pending_bits.sv
// Per-way-group saturating pending counters for the CCE.
// One write port, one registered read port with write-first bypass, and a sticky error flag.
module bp_cce_pending_bits #(
  parameter int num_way_groups_p          = 64,
  parameter int cnt_width_p               = 3,
  parameter int paddr_width_p             = 40,
  parameter int lg_block_size_in_bytes_lp = 6
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     w_v_i,
  input  logic [paddr_width_p-1:0] w_addr_i,
  input  logic                     pending_i,
  input  logic                     clear_i,

  input  logic                     r_v_i,
  input  logic [paddr_width_p-1:0] r_addr_i,

  output logic                     pending_v_o,
  output logic                     pending_o,
  output logic [cnt_width_p-1:0]   cnt_o,
  output logic                     err_o
);

  localparam int lg_groups_lp = $clog2(num_way_groups_p);
  localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

  logic [lg_groups_lp-1:0] w_grp, r_grp;
  logic [cnt_width_p-1:0]  cnt_q [num_way_groups_p];
  logic [cnt_width_p-1:0]  w_cur, w_new, rd_cnt;
  logic                    w_err;

  logic                    pending_v_q, pending_v_d;
  logic                    pending_q, pending_d;
  logic [cnt_width_p-1:0]  cnt_out_q, cnt_out_d;
  logic                    err_q, err_d;

  // Address bits outside the group index do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{w_addr_i, r_addr_i};

  assign w_grp = w_addr_i[lg_block_size_in_bytes_lp +: lg_groups_lp];
  assign r_grp = r_addr_i[lg_block_size_in_bytes_lp +: lg_groups_lp];

  always_comb begin
    w_cur = cnt_q[w_grp];
    w_new = w_cur;
    w_err = 1'b0;
    if (clear_i) begin
      w_new = '0;
    end else if (pending_i) begin
      if (w_cur == cnt_max_lp) w_err = 1'b1;
      else                     w_new = w_cur + cnt_width_p'(1);
    end else begin
      if (w_cur == '0) w_err = 1'b1;
      else             w_new = w_cur - cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_way_groups_p; i++) cnt_q[i] <= '0;
    end else if (w_v_i) begin
      cnt_q[w_grp] <= w_new;
    end
  end

  // Same-group read sees the value this cycle's write is about to store.
  assign rd_cnt = (w_v_i && (w_grp == r_grp)) ? w_new : cnt_q[r_grp];

  always_comb begin
    pending_v_d = r_v_i;
    pending_d   = pending_q;
    cnt_out_d   = cnt_out_q;
    err_d       = err_q | (w_v_i & w_err);
    if (r_v_i) begin
      pending_d = |rd_cnt;
      cnt_out_d = rd_cnt;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_v_q <= 1'b0;
      pending_q   <= 1'b0;
      cnt_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      pending_v_q <= pending_v_d;
      pending_q   <= pending_d;
      cnt_out_q   <= cnt_out_d;
      err_q       <= err_d;
    end
  end

  assign pending_v_o = pending_v_q;
  assign pending_o   = pending_q;
  assign cnt_o       = cnt_out_q;
  assign err_o       = err_q;

endmodule

// File: doc/bp_cce_pending_bits.md
BP_CCE_PENDING_BITS -- requirements
Module: bp_cce_pending_bits

Interface
REQ-001 Parameter num_way_groups_p, default 64, number of tracked way groups; power of two, at least 2.
REQ-002 Parameter cnt_width_p, default 3, width of each per-group pending counter.
REQ-003 Parameter paddr_width_p, default 40, physical address width.
REQ-004 Parameter lg_block_size_in_bytes_lp, default 6, log2 of the cache block size in bytes.
REQ-005 clk_i  in  1  single clock; all state is rising-edge.
REQ-006 reset_n_i  in  1  asynchronous, active-low reset.
REQ-007 w_v_i  in  1  write request this cycle.
REQ-008 w_addr_i  in  paddr_width_p  address selecting the group to write.
REQ-009 pending_i  in  1  1 = increment, 0 = decrement.
REQ-010 clear_i  in  1  with w_v_i, force the selected counter to 0.
REQ-011 r_v_i  in  1  read request this cycle.
REQ-012 r_addr_i  in  paddr_width_p  address selecting the group to read.
REQ-013 pending_v_o  out  1  read result valid, one cycle after r_v_i.
REQ-014 pending_o  out  1  1 if the read counter is non-zero; drives the register file's pending_i for the RDP instruction.
REQ-015 cnt_o  out  cnt_width_p  raw counter value of the read group, for debug.
REQ-016 err_o  out  1  sticky flag for an overflow or underflow event.

Function
REQ-017 Group index is addr[lg_block_size_in_bytes_lp +: log2(num_way_groups_p)]. Upper address bits are ignored.
REQ-018 Each group holds one saturating counter of cnt_width_p bits.
REQ-019 Write when w_v_i=1. The selected counter updates at the next edge, with this priority:
- clear_i=1: counter becomes 0.
- else pending_i=1: counter becomes counter+1.
- else: counter becomes counter-1.
REQ-020 Increment at the maximum value 2^cnt_width_p-1 leaves the counter unchanged and sets err_o.
REQ-021 Decrement at 0 leaves the counter unchanged and sets err_o.
REQ-022 clear_i never sets err_o.
REQ-023 err_o stays at 1 until reset.
REQ-024 Read latency is exactly 1 cycle: r_v_i in cycle N gives pending_v_o=1 in cycle N+1, with pending_o and cnt_o registered.
REQ-025 pending_v_o is 0 in any cycle not following an r_v_i.
REQ-026 When pending_v_o=0, pending_o and cnt_o hold their last values.
REQ-027 A read and a write to the same group in the same cycle return the post-write value (write-first bypass). This includes the clear, saturation and error cases.
REQ-028 A read and a write to different groups in the same cycle are independent. The read returns the pre-edge value of its own group.
REQ-029 Only one write port exists, so at most one counter changes per cycle. All other counters hold.
REQ-030 No handshake and no backpressure: every valid request is accepted in the cycle it is presented.
REQ-031 Request inputs are ignored when their valid is 0.
REQ-032 Combinational paths: no input reaches any output without passing through a flop.

Reset
REQ-033 While reset_n_i=0, asynchronously and independent of clk_i:
- all counters = 0
- pending_v_o = 0, pending_o = 0, cnt_o = 0, err_o = 0
REQ-034 A reset asserted mid-operation discards any in-flight read result and any write that has not yet been captured.
REQ-035 The first edge after reset_n_i deasserts accepts requests normally. No initialization sweep is performed.

Verification
REQ-036 Basic increment and read:
- stimulus: after reset, write addr 0x1040 (group 1) with pending_i=1 twice, then read group 1.
- required response: next cycle pending_v_o=1, pending_o=1, cnt_o=2, err_o=0.
REQ-037 Decrement to zero with same-cycle bypass:
- stimulus: group 1 at 2; decrement twice; on the second decrement also read 0x1040.
- required response: next cycle pending_o=0, cnt_o=0.
REQ-038 Saturation:
- stimulus: with cnt_width_p=3, increment group 5 eight times, then read it.
- required response: cnt_o=7, err_o=1; decrementing once afterwards gives 6 and err_o stays 1.
REQ-039 Underflow and clear priority:
- stimulus: decrement group 9 at 0; then w_v_i=1 with clear_i=1 and pending_i=1 on group 9.
- required response: err_o=1; counter=0; neither counter changes on the clear write.
REQ-040 Aliasing and independence:
- stimulus: increment 0x0_0040 and 0x1_0040 (same group 1 when num_way_groups_p=64); in the same cycle as the second write, read group 2.
- required response: group 1 = 2; the group 2 read returns 0.
REQ-041 Asynchronous reset mid-operation:
- stimulus: with a read outstanding and group 3 at 4, pull reset_n_i low between clock edges.
- required response: all outputs 0 immediately; group 3 reads 0 after release.
